ddr_train_monitor: RTL
======================

DDR_TRAIN_MONITOR -- requirements
Module: ddr_train_monitor

Interface
REQ-001 SHALL have parameter STAGE_NUM, default 5, number of ordered training stages (init, wrlvl, rdcal, wrcal, eyecal).
REQ-002 SHALL have parameter TS_WIDTH, default 32, width of the cycle counter and of each timestamp.
REQ-003 SHALL have parameter ERR_WIDTH, default 8, width of the PHY error status vector.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1000000, maximum cycles allowed between stage events.
REQ-005 SHALL have local parameter SEL_W = max(1, clog2(STAGE_NUM)).
REQ-006 SHALL have clk  input  1  single monitor clock; all logic on its rising edge.
REQ-007 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have start  input  1  level; high = PHY out of reset, training running.
REQ-009 SHALL have clr  input  1  one-cycle pulse; returns DONE/FAIL to IDLE.
REQ-010 SHALL have stage_done  input  STAGE_NUM  per-stage done levels from the PHY main controller.
REQ-011 SHALL have error_status  input  ERR_WIDTH  PHY error vector; nonzero = training error.
REQ-012 SHALL have rd_sel  input  SEL_W  timestamp read index.
REQ-013 SHALL have rd_ts  output  TS_WIDTH  registered timestamp of stage rd_sel.
REQ-014 SHALL have cur_stage  output  SEL_W+1  index of the next expected stage (STAGE_NUM when all done).
REQ-015 SHALL have train_ok, train_fail  outputs  1 each  sticky result flags.
REQ-016 SHALL have fail_code  output  2  0 none, 1 PHY error, 2 order error, 3 timeout.
REQ-017 SHALL have err_code  output  ERR_WIDTH  error_status captured at the PHY-error failure.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE, FAIL.
REQ-019 SHALL, in IDLE with start=1, enter RUN next cycle with cycle counter and stage timer at 0, cur_stage 0, stage_done edge history captured from the current inputs.
REQ-020 SHALL, in RUN, increment the cycle counter each cycle, saturating at all-ones.
REQ-021 SHALL detect stage events as 0->1 transitions of stage_done bits against a registered copy.
REQ-022 SHALL, on a rising edge of exactly bit cur_stage, store the current cycle count in ts[cur_stage], increment cur_stage, clear the stage timer.
REQ-023 SHALL, on any rising edge of a bit other than cur_stage (alone or with cur_stage in the same cycle), enter FAIL with fail_code 2.
REQ-024 SHALL, when cur_stage reaches STAGE_NUM, enter DONE next cycle and set train_ok.
REQ-025 SHALL, in RUN with error_status nonzero, enter FAIL, fail_code 1, err_code = error_status; PHY error has priority over stage events and timeout in the same cycle.
REQ-026 SHALL, when the stage timer reaches TIMEOUT_CYC-1 in RUN, enter FAIL with fail_code 3; order error has priority over timeout.
REQ-027 SHALL hold train_ok/train_fail/fail_code/err_code/ts in DONE and FAIL until clr; error_status and stage_done ignored there.
REQ-028 SHALL, on clr in DONE/FAIL, return to IDLE clearing flags, codes, cur_stage; timestamps retained until the next RUN entry clears them.
REQ-029 SHALL, on start falling in RUN, abort to IDLE with flags unchanged (0); clr in IDLE/RUN has no effect.
REQ-030 SHALL update rd_ts one cycle after rd_sel; rd_sel >= STAGE_NUM returns 0.
REQ-031 SHALL drive train_fail = (state==FAIL), train_ok = (state==DONE), registered.

Reset
REQ-032 SHALL, on rst_n low, asynchronously force IDLE, all counters, ts entries, rd_ts, cur_stage, flags, fail_code, err_code to 0.
REQ-033 SHALL, on reset mid-RUN, discard progress; no flag asserts until a new start.

Verification
REQ-034 Nominal: start=1, bits 0..4 rise at cycles 100,200,300,400,500 -> ts = 100..500 (+fixed entry offset), cur_stage 5, train_ok=1, fail_code 0.
REQ-035 Order error: bit 2 rises while cur_stage=1 -> train_fail=1, fail_code 2, cur_stage 1.
REQ-036 PHY error: error_status=8'h04 in same cycle as bit 0 rise -> fail_code 1, err_code 8'h04, ts[0] not written.
REQ-037 Timeout: TIMEOUT_CYC=50, no event after stage 1 -> FAIL fail_code 3 exactly 50 cycles after stage-1 event.
REQ-038 Abort/reset: start falls at stage 3 -> IDLE, flags 0; rst_n low mid-RUN -> all outputs 0 immediately; clr after DONE -> IDLE, train_ok 0.

Source files
------------

// File: rtl/ddr_train_monitor.sv
// rtl/ddr_train_monitor.sv - DDR PHY training progress monitor with per-stage timestamps
module ddr_train_monitor #(
    parameter int STAGE_NUM   = 5,
    parameter int TS_WIDTH    = 32,
    parameter int ERR_WIDTH   = 8,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int SEL_W      = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clr,
    input  logic [STAGE_NUM-1:0] stage_done,
    input  logic [ERR_WIDTH-1:0] error_status,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic [TS_WIDTH-1:0]  rd_ts,
    output logic [SEL_W:0]       cur_stage,
    output logic                 train_ok,
    output logic                 train_fail,
    output logic [1:0]           fail_code,
    output logic [ERR_WIDTH-1:0] err_code
);
    localparam int CS_W = SEL_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

    state_t                 state_q, state_d;
    logic [TS_WIDTH-1:0]    cyc_q, cyc_d;
    logic [TS_WIDTH-1:0]    timer_q, timer_d;
    logic [CS_W-1:0]        cur_q, cur_d;
    logic [STAGE_NUM-1:0]   prev_q, prev_d;
    logic [TS_WIDTH-1:0]    ts_q [STAGE_NUM];
    logic [TS_WIDTH-1:0]    ts_d [STAGE_NUM];
    logic [TS_WIDTH-1:0]    rd_ts_q, rd_ts_d;
    logic                   ok_q, ok_d, fail_q, fail_d;
    logic [1:0]             fail_code_q, fail_code_d;
    logic [ERR_WIDTH-1:0]   err_code_q, err_code_d;

    logic [STAGE_NUM-1:0]   rise, exp_mask;
    logic                   hit, bad, phy_err, tmo, last, take;

    always_comb begin
        rise = stage_done & ~prev_q;
        for (int i = 0; i < STAGE_NUM; i++) begin
            exp_mask[i] = (cur_q == CS_W'(i));
        end
        hit     = |(rise & exp_mask);
        bad     = |(rise & ~exp_mask);
        phy_err = |error_status;
        tmo     = (timer_q == TS_WIDTH'(TIMEOUT_CYC - 1));
        last    = hit && (cur_q == CS_W'(STAGE_NUM - 1));
        take    = start && hit && !bad && !phy_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            timer_q     <= '0;
            cur_q       <= '0;
            prev_q      <= '0;
            rd_ts_q     <= '0;
            ok_q        <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= 2'd0;
            err_code_q  <= '0;
            for (int i = 0; i < STAGE_NUM; i++) begin
                ts_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            timer_q     <= timer_d;
            cur_q       <= cur_d;
            prev_q      <= prev_d;
            rd_ts_q     <= rd_ts_d;
            ok_q        <= ok_d;
            fail_q      <= fail_d;
            fail_code_q <= fail_code_d;
            err_code_q  <= err_code_d;
            for (int i = 0; i < STAGE_NUM; i++) begin
                ts_q[i] <= ts_d[i];
            end
        end
    end

    // Priority in RUN: abort, PHY error, order error, then timeout unless a valid event lands
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (!start)           state_d = IDLE;
                else if (phy_err)     state_d = FAIL;
                else if (bad)         state_d = FAIL;
                else if (last)        state_d = DONE;
                else if (!hit && tmo) state_d = FAIL;
            end
            DONE, FAIL: if (clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_d       = cyc_q;
        timer_d     = timer_q;
        cur_d       = cur_q;
        prev_d      = stage_done;
        fail_code_d = fail_code_q;
        err_code_d  = err_code_q;
        for (int i = 0; i < STAGE_NUM; i++) begin
            ts_d[i] = ts_q[i];
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    cyc_d   = '0;
                    timer_d = '0;
                    cur_d   = '0;
                    for (int i = 0; i < STAGE_NUM; i++) begin
                        ts_d[i] = '0;
                    end
                end
            end
            RUN: begin
                cyc_d   = (&cyc_q) ? cyc_q : cyc_q + TS_WIDTH'(1);
                timer_d = take ? '0 : timer_q + TS_WIDTH'(1);
                if (take) begin
                    cur_d = cur_q + CS_W'(1);
                    for (int i = 0; i < STAGE_NUM; i++) begin
                        if (cur_q == CS_W'(i)) ts_d[i] = cyc_q;
                    end
                end
                if (state_d == FAIL) begin
                    if (phy_err) begin
                        fail_code_d = 2'd1;
                        err_code_d  = error_status;
                    end else if (bad) begin
                        fail_code_d = 2'd2;
                    end else begin
                        fail_code_d = 2'd3;
                    end
                end
            end
            DONE, FAIL: begin
                if (clr) begin
                    fail_code_d = 2'd0;
                    err_code_d  = '0;
                    cur_d       = '0;
                end
            end
            default: ;
        endcase
        rd_ts_d = '0;
        for (int i = 0; i < STAGE_NUM; i++) begin
            if (rd_sel == SEL_W'(i)) rd_ts_d = ts_q[i];
        end
        ok_d   = (state_d == DONE);
        fail_d = (state_d == FAIL);
    end

    assign rd_ts      = rd_ts_q;
    assign cur_stage  = cur_q;
    assign train_ok   = ok_q;
    assign train_fail = fail_q;
    assign fail_code  = fail_code_q;
    assign err_code   = err_code_q;
endmodule
